// File: rtl/rect80_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : rect80_key_sched
// Purpose  : 80-bit RECTANGLE-style key schedule. Loads a master key on
//            i_start and produces round keys K0..K25, advancing one round
//            per i_next. After K25 is consumed, o_done pulses for one cycle.
// Ports    : i_clk        - clock, rising edge
//            i_rst_n      - asynchronous active-low reset
//            i_start      - load iv_key and begin the schedule (IDLE only)
//            iv_key       - master key, Row r at bits [16r+15:16r]
//            i_next       - advance to the next round key (RUN only)
//            ov_key80     - current 80-bit key state, same row packing
//            ov_roundkey  - current round key {Row3,Row2,Row1,Row0}
//            ov_round     - index of the round key presented (0..25)
//            o_valid      - ov_roundkey/ov_key80 hold K_r
//            o_busy       - schedule in progress
//            o_done       - one-cycle pulse after K25 is consumed
// Options  : RECT80_KS_RELOAD_EN - keep a copy of the master key and restart
//            the schedule automatically after DONE.
// Revision : 1.0 - initial release
// ============================================================================
module rect80_key_sched (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [79:0] iv_key,
  input  logic        i_next,
  output logic [79:0] ov_key80,
  output logic [63:0] ov_roundkey,
  output logic [4:0]  ov_round,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [4:0] c_RC_INIT    = 5'h01;
  localparam logic [4:0] c_LAST_ROUND = 5'd25;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [79:0] r_key;
  logic [4:0]  r_rc;
  logic [4:0]  r_round;
  logic        w_load;
  logic        w_advance;
  logic        w_reload;
  logic [79:0] w_key_upd;
  logic [4:0]  w_rc_upd;

  function automatic logic [3:0] f_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h6;  4'h1: y = 4'h5;  4'h2: y = 4'hC;  4'h3: y = 4'hA;
      4'h4: y = 4'h1;  4'h5: y = 4'hE;  4'h6: y = 4'h7;  4'h7: y = 4'h9;
      4'h8: y = 4'hB;  4'h9: y = 4'h0;  4'hA: y = 4'h3;  4'hB: y = 4'hD;
      4'hC: y = 4'h8;  4'hD: y = 4'hF;  4'hE: y = 4'h4;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Round update: S-box over the four low columns (a column is one bit from
  // each of Row0..Row3), then the generalized Feistel row mix, then rc.
  always_comb begin
    logic [15:0] w_row [5];
    logic [3:0]  w_nib;
    for (int r = 0; r < 5; r++) begin
      w_row[r] = r_key[16*r +: 16];
    end
    for (int j = 0; j < 4; j++) begin
      w_nib = f_sbox({w_row[3][j], w_row[2][j], w_row[1][j], w_row[0][j]});
      for (int r = 0; r < 4; r++) begin
        w_row[r][j] = w_nib[r];
      end
    end
    w_key_upd = {
      w_row[0],                                         // Row4'
      {w_row[3][3:0], w_row[3][15:4]} ^ w_row[4],       // Row3' (rotl 12)
      w_row[3],                                         // Row2'
      w_row[2],                                         // Row1'
      {w_row[0][7:0], w_row[0][15:8]} ^ w_row[1] ^ {11'd0, r_rc}  // Row0'
    };
    w_rc_upd = {r_rc[3:0], r_rc[4] ^ r_rc[2]};
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    w_reload    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_next) begin
          if (r_round == c_LAST_ROUND) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      ST_DONE: begin
`ifdef RECT80_KS_RELOAD_EN
        w_reload    = 1'b1;
        w_state_nxt = ST_RUN;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef RECT80_KS_RELOAD_EN
  logic [79:0] r_master;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_master <= 80'd0;
    end else if (w_load) begin
      r_master <= iv_key;
    end
  end
`endif

  // Key state, round constant and round index
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_key   <= 80'd0;
      r_rc    <= c_RC_INIT;
      r_round <= 5'd0;
    end else if (w_load) begin
      r_key   <= iv_key;
      r_rc    <= c_RC_INIT;
      r_round <= 5'd0;
    end else if (w_advance) begin
      r_key   <= w_key_upd;
      r_rc    <= w_rc_upd;
      r_round <= r_round + 5'd1;
    end else if (w_reload) begin
`ifdef RECT80_KS_RELOAD_EN
      r_key   <= r_master;
`endif
      r_rc    <= c_RC_INIT;
      r_round <= 5'd0;
    end
  end

  assign ov_key80    = r_key;
  assign ov_roundkey = r_key[63:0];
  assign ov_round    = r_round;
  assign o_valid     = (r_state == ST_RUN);
  assign o_busy      = (r_state == ST_RUN);
  assign o_done      = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rect80_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_rect80_key_sched
// Purpose  : Self-checking bench for rect80_key_sched. A row/array-level
//            reference model tracks the expected key schedule and outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rect80_key_sched;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [79:0] iv_key;
  logic        i_next;
  logic [79:0] ov_key80;
  logic [63:0] ov_roundkey;
  logic [4:0]  ov_round;
  logic        o_valid;
  logic        o_busy;
  logic        o_done;

  rect80_key_sched u_dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .iv_key      (iv_key),
    .i_next      (i_next),
    .ov_key80    (ov_key80),
    .ov_roundkey (ov_roundkey),
    .ov_round    (ov_round),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: rows as an array, phase as 0=idle 1=run 2=done
  const logic [3:0] SBOX [16] = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
                                  4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};
  logic [15:0] m_row [5];
  logic [4:0]  m_rc;
  logic [4:0]  m_round;
  logic [79:0] m_master;
  int          m_st;

  task automatic m_reset();
    for (int r = 0; r < 5; r++) m_row[r] = 16'd0;
    m_rc = 5'h01; m_round = 5'd0; m_st = 0; m_master = 80'd0;
  endtask

  task automatic m_load(input logic [79:0] k);
    for (int r = 0; r < 5; r++) m_row[r] = k[16*r +: 16];
    m_rc = 5'h01; m_round = 5'd0;
  endtask

  task automatic m_update();
    logic [15:0] a [5];
    int nib;
    int s;
    for (int r = 0; r < 5; r++) a[r] = m_row[r];
    for (int j = 0; j < 4; j++) begin
      nib = 8 * a[3][j] + 4 * a[2][j] + 2 * a[1][j] + a[0][j];
      s = SBOX[nib];
      for (int r = 0; r < 4; r++) a[r][j] = ((s >> r) & 1) != 0;
    end
    m_row[0] = ((a[0] << 8) | (a[0] >> 8)) ^ a[1] ^ {11'd0, m_rc};
    m_row[1] = a[2];
    m_row[2] = a[3];
    m_row[3] = ((a[3] << 12) | (a[3] >> 4)) ^ a[4];
    m_row[4] = a[0];
    m_rc     = {m_rc[3:0], m_rc[4] ^ m_rc[2]};
    m_round  = m_round + 5'd1;
  endtask

  task automatic m_step(input logic st, input logic nx, input logic [79:0] k);
    case (m_st)
      0: if (st) begin m_load(k); m_master = k; m_st = 1; end
      1: if (nx) begin
           if (m_round == 5'd25) m_st = 2;
           else m_update();
         end
      default: begin
`ifdef RECT80_KS_RELOAD_EN
        m_load(m_master); m_st = 1;
`else
        m_st = 0;
`endif
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [79:0] k;
    k = {m_row[4], m_row[3], m_row[2], m_row[1], m_row[0]};
    chk({tag, ".key80"},    ov_key80, k);
    chk({tag, ".roundkey"}, {16'd0, ov_roundkey}, {16'd0, k[63:0]});
    chk({tag, ".round"},    {75'd0, ov_round}, {75'd0, m_round});
    chk({tag, ".valid"},    {79'd0, o_valid}, {79'd0, m_st == 1});
    chk({tag, ".busy"},     {79'd0, o_busy},  {79'd0, m_st == 1});
    chk({tag, ".done"},     {79'd0, o_done},  {79'd0, m_st == 2});
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic cyc(input logic st, input logic nx, input logic [79:0] k, input string tag);
    i_start = st; i_next = nx; iv_key = k;
    @(posedge i_clk);
    #1;
    m_step(st, nx, k);
    i_start = 1'b0; i_next = 1'b0;
    check_all(tag);
  endtask

  function automatic logic [79:0] rnd80();
    return {$urandom(), $urandom(), $urandom()} & {80{1'b1}};
  endfunction

  initial begin
    logic [79:0] k;
    i_rst_n = 1'b0; i_start = 1'b0; i_next = 1'b0; iv_key = 80'd0;
    m_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_all("reset");
    i_rst_n = 1'b1;

    // next in IDLE after reset release changes nothing
    cyc(1'b0, 1'b1, 80'd0, "idle_next");
    cyc(1'b0, 1'b0, 80'd0, "idle_hold");

    // zero key: K0 and K1 against fixed values
    cyc(1'b1, 1'b0, 80'd0, "start0");
    chk("k0.roundkey", {16'd0, ov_roundkey}, 80'd0);
    chk("k0.flags", {75'd0, o_valid, o_busy, ov_round}, {75'd0, 1'b1, 1'b1, 5'd0});
    cyc(1'b0, 1'b1, 80'd0, "next1");
    chk("k1.roundkey", {16'd0, ov_roundkey}, {16'd0, 64'h0000_0000_000F_000E});
    chk("k1.row4", {64'd0, ov_key80[79:64]}, 80'd0);
    chk("k1.round", {75'd0, ov_round}, 80'd1);

    // remaining rounds back-to-back, then the consuming next
    for (int i = 2; i <= 25; i++) cyc(1'b0, 1'b1, 80'd0, "b2b");
    chk("k25.round", {75'd0, ov_round}, 80'd25);
    cyc(1'b0, 1'b1, 80'd0, "consume25");
    chk("done.pulse", {78'd0, o_done, o_valid}, {78'd0, 1'b1, 1'b0});
    cyc(1'b0, 1'b0, 80'd0, "after_done");
`ifdef RECT80_KS_RELOAD_EN
    chk("reload.rk", {16'd0, ov_roundkey}, 80'd0);
    chk("reload.round", {75'd0, ov_round, o_valid}, {75'd0, 5'd0, 1'b1});
`else
    chk("idle.round_hold", {75'd0, ov_round}, 80'd25);
    chk("idle.done_clear", {78'd0, o_done, o_valid}, 80'd0);
    cyc(1'b0, 1'b0, 80'd0, "idle_after");
`endif

    // start and next together in IDLE: start wins
    k = rnd80();
    cyc(1'b1, 1'b1, k, "start_and_next");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 80'd0, "adv");
    // start is ignored in RUN; holding next low keeps everything stable
    cyc(1'b1, 1'b0, {80{1'b1}}, "start_in_run");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 80'd0, "hold");

    // asynchronous reset in the middle of round 10
    cyc(1'b0, 1'b0, 80'd0, "pre");
    while (m_round < 5'd10 && m_st == 1) cyc(1'b0, 1'b1, 80'd0, "to_r10");
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    m_reset();
    check_all("async_rst");
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    cyc(1'b0, 1'b1, 80'd0, "next_after_rst");

    // random keys with random next/start traffic
    for (int t = 0; t < 3; t++) begin
      k = rnd80();
      cyc(1'b1, 1'b0, k, "rnd_start");
      for (int c = 0; c < 120; c++) begin
        cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), rnd80(), "rnd");
        if (m_st == 0) break;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
